// File: rtl/tensor_core_pkg.sv
// Shared types and constants for the tensor core job scheduler.
//   BUS_WIDTH         - default element width in bits
//   MATRIX_DIM        - side length of the square operand/result matrices
//   element_t         - one matrix element
//   matrix_t          - MATRIX_DIM x MATRIX_DIM matrix of element_t
//   scheduler_state_t - scheduler FSM states
//   wrap_inc()        - modulo-n increment used for the round-robin pointer
package tensor_core_pkg;

    localparam int unsigned BUS_WIDTH  = 8;
    localparam int unsigned MATRIX_DIM = 4;

    typedef logic [BUS_WIDTH-1:0] element_t;
    typedef element_t [MATRIX_DIM-1:0][MATRIX_DIM-1:0] matrix_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMPUTE,
        RESPOND
    } scheduler_state_t;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/round_robin_arbiter.sv
// Combinational round-robin arbiter.
//   request     - per-client request vector
//   pointer     - highest-priority index for this decision
//   grant       - one-hot grant (zero when nothing requests)
//   grant_index - binary index of the granted client
//   any_grant   - at least one client was granted
module round_robin_arbiter #(
    parameter int unsigned N         = 4,
    parameter int unsigned IDX_WIDTH = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]         request,
    input  logic [IDX_WIDTH-1:0] pointer,
    output logic [N-1:0]         grant,
    output logic [IDX_WIDTH-1:0] grant_index,
    output logic                 any_grant
);

    int unsigned idx;

    // Scan N slots starting at the pointer; the first requester found wins.
    always_comb begin
        grant       = '0;
        grant_index = '0;
        any_grant   = 1'b0;
        idx         = 0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = (32'(pointer) + off) % N;
            if (!any_grant && request[idx]) begin
                any_grant      = 1'b1;
                grant[idx]     = 1'b1;
                grant_index    = IDX_WIDTH'(idx);
            end
        end
    end

endmodule

// File: rtl/tensor_core_job_scheduler.sv
// Shares one 4x4 tensor core among NUM_REQUESTERS clients.
//   clock_in / reset_n_in          - clock, asynchronous active-low reset
//   request_valid/ready            - per-client job handshake (ready is one-hot, IDLE only)
//   request_input1/2               - per-client A and B operand matrices
//   tensor_core_register_file_write_enable - one-cycle core start pulse (LOAD state)
//   tensor_core_input1/2           - latched operands, held from LOAD until RESPOND exits
//   tensor_core_output             - core result
//   is_done_with_calculation       - core done flag
//   response_valid/ready/id/data/error - result channel back to the winning client
//   busy                           - scheduler is not IDLE
//   jobs_completed                 - saturating count of error-free responses
module tensor_core_job_scheduler
    import tensor_core_pkg::*;
#(
    parameter int unsigned NUM_REQUESTERS = 4,
    parameter int unsigned BUS_WIDTH      = tensor_core_pkg::BUS_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned ID_WIDTH       = $clog2(NUM_REQUESTERS)
) (
    input  logic                                                           clock_in,
    input  logic                                                           reset_n_in,
    input  logic [NUM_REQUESTERS-1:0]                                      request_valid,
    output logic [NUM_REQUESTERS-1:0]                                      request_ready,
    input  logic [NUM_REQUESTERS-1:0][MATRIX_DIM-1:0][MATRIX_DIM-1:0][BUS_WIDTH-1:0] request_input1,
    input  logic [NUM_REQUESTERS-1:0][MATRIX_DIM-1:0][MATRIX_DIM-1:0][BUS_WIDTH-1:0] request_input2,
    output logic                                                           tensor_core_register_file_write_enable,
    output logic [MATRIX_DIM-1:0][MATRIX_DIM-1:0][BUS_WIDTH-1:0]           tensor_core_input1,
    output logic [MATRIX_DIM-1:0][MATRIX_DIM-1:0][BUS_WIDTH-1:0]           tensor_core_input2,
    input  logic [MATRIX_DIM-1:0][MATRIX_DIM-1:0][BUS_WIDTH-1:0]           tensor_core_output,
    input  logic                                                           is_done_with_calculation,
    output logic                                                           response_valid,
    input  logic                                                           response_ready,
    output logic [ID_WIDTH-1:0]                                            response_id,
    output logic [MATRIX_DIM-1:0][MATRIX_DIM-1:0][BUS_WIDTH-1:0]           response_data,
    output logic                                                           response_error,
    output logic                                                           busy,
    output logic [15:0]                                                    jobs_completed
);

    typedef logic [MATRIX_DIM-1:0][MATRIX_DIM-1:0][BUS_WIDTH-1:0] mat_t;

    localparam int unsigned WD_WIDTH = $clog2(TIMEOUT_CYCLES) + 1;

    scheduler_state_t state_q, state_d;
    logic [ID_WIDTH-1:0] rr_pointer_q, rr_pointer_d;
    logic [ID_WIDTH-1:0] response_id_q, response_id_d;
    logic [WD_WIDTH-1:0] watchdog_q, watchdog_d;
    mat_t                operand1_q, operand1_d;
    mat_t                operand2_q, operand2_d;
    mat_t                response_data_q, response_data_d;
    logic                response_error_q, response_error_d;
    logic                response_valid_q, response_valid_d;
    logic                write_enable_q, write_enable_d;
    logic                busy_q, busy_d;
    logic [15:0]         jobs_completed_q, jobs_completed_d;

    logic [NUM_REQUESTERS-1:0] grant_onehot;
    logic [ID_WIDTH-1:0]       grant_index;
    logic                      any_grant;

    round_robin_arbiter #(
        .N         (NUM_REQUESTERS),
        .IDX_WIDTH (ID_WIDTH)
    ) u_arbiter (
        .request     (request_valid),
        .pointer     (rr_pointer_q),
        .grant       (grant_onehot),
        .grant_index (grant_index),
        .any_grant   (any_grant)
    );

    // Ready is gated by reset too so nothing can be accepted while reset is asserted.
    assign request_ready = ((state_q == IDLE) && reset_n_in) ? grant_onehot : '0;

    always_comb begin
        state_d          = state_q;
        rr_pointer_d     = rr_pointer_q;
        response_id_d    = response_id_q;
        watchdog_d       = watchdog_q;
        operand1_d       = operand1_q;
        operand2_d       = operand2_q;
        response_data_d  = response_data_q;
        response_error_d = response_error_q;
        response_valid_d = response_valid_q;
        write_enable_d   = write_enable_q;
        busy_d           = busy_q;
        jobs_completed_d = jobs_completed_q;

        case (state_q)
            IDLE: begin
                if (any_grant) begin
                    operand1_d     = request_input1[grant_index];
                    operand2_d     = request_input2[grant_index];
                    response_id_d  = grant_index;
                    write_enable_d = 1'b1;
                    busy_d         = 1'b1;
                    state_d        = LOAD;
                end
            end
            LOAD: begin
                write_enable_d = 1'b0;
                watchdog_d     = '0;
                state_d        = COMPUTE;
            end
            COMPUTE: begin
                watchdog_d = watchdog_q + 1'b1;
                // watchdog_q == 0 marks the first COMPUTE cycle, where a done flag
                // left over from the previous job must not be trusted.
                if (is_done_with_calculation && (watchdog_q != '0)) begin
                    response_data_d  = tensor_core_output;
                    response_error_d = 1'b0;
                    response_valid_d = 1'b1;
                    state_d          = RESPOND;
                end else if (watchdog_q == WD_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                    response_data_d  = '0;
                    response_error_d = 1'b1;
                    response_valid_d = 1'b1;
                    state_d          = RESPOND;
                end
            end
            RESPOND: begin
                if (response_ready) begin
                    response_valid_d = 1'b0;
                    busy_d           = 1'b0;
                    rr_pointer_d     = ID_WIDTH'(wrap_inc(32'(response_id_q), NUM_REQUESTERS));
                    if (!response_error_q && (jobs_completed_q != 16'hFFFF)) begin
                        jobs_completed_d = jobs_completed_q + 16'd1;
                    end
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q          <= IDLE;
            rr_pointer_q     <= '0;
            response_id_q    <= '0;
            watchdog_q       <= '0;
            operand1_q       <= '0;
            operand2_q       <= '0;
            response_data_q  <= '0;
            response_error_q <= 1'b0;
            response_valid_q <= 1'b0;
            write_enable_q   <= 1'b0;
            busy_q           <= 1'b0;
            jobs_completed_q <= '0;
        end else begin
            state_q          <= state_d;
            rr_pointer_q     <= rr_pointer_d;
            response_id_q    <= response_id_d;
            watchdog_q       <= watchdog_d;
            operand1_q       <= operand1_d;
            operand2_q       <= operand2_d;
            response_data_q  <= response_data_d;
            response_error_q <= response_error_d;
            response_valid_q <= response_valid_d;
            write_enable_q   <= write_enable_d;
            busy_q           <= busy_d;
            jobs_completed_q <= jobs_completed_d;
        end
    end

    assign tensor_core_register_file_write_enable = write_enable_q;
    assign tensor_core_input1 = operand1_q;
    assign tensor_core_input2 = operand2_q;
    assign response_valid     = response_valid_q;
    assign response_id        = response_id_q;
    assign response_data      = response_data_q;
    assign response_error     = response_error_q;
    assign busy               = busy_q;
    assign jobs_completed     = jobs_completed_q;

endmodule

// File: tb/tb_tensor_core_job_scheduler.sv
module tb_tensor_core_job_scheduler;

    localparam int N  = 4;
    localparam int T  = 64;

    typedef logic [3:0][3:0][7:0] mat_t;
    typedef struct {
        int   id;
        mat_t data;
        bit   err;
        int   lat;
        int   jobs;
    } resp_t;

    logic             clock_in = 1'b0;
    logic             reset_n_in = 1'b0;
    logic [N-1:0]     request_valid;
    logic [N-1:0]     request_ready;
    logic [N-1:0][3:0][3:0][7:0] request_input1 = '0;
    logic [N-1:0][3:0][3:0][7:0] request_input2 = '0;
    logic             tensor_core_register_file_write_enable;
    mat_t             tensor_core_input1, tensor_core_input2;
    mat_t             tensor_core_output;
    logic             is_done_with_calculation;
    logic             response_valid;
    logic             response_ready = 1'b1;
    logic [1:0]       response_id;
    mat_t             response_data;
    logic             response_error;
    logic             busy;
    logic [15:0]      jobs_completed;

    tensor_core_job_scheduler #(
        .NUM_REQUESTERS (N),
        .BUS_WIDTH      (8),
        .TIMEOUT_CYCLES (T),
        .ID_WIDTH       (2)
    ) dut (
        .clock_in                               (clock_in),
        .reset_n_in                             (reset_n_in),
        .request_valid                          (request_valid),
        .request_ready                          (request_ready),
        .request_input1                         (request_input1),
        .request_input2                         (request_input2),
        .tensor_core_register_file_write_enable (tensor_core_register_file_write_enable),
        .tensor_core_input1                     (tensor_core_input1),
        .tensor_core_input2                     (tensor_core_input2),
        .tensor_core_output                     (tensor_core_output),
        .is_done_with_calculation               (is_done_with_calculation),
        .response_valid                         (response_valid),
        .response_ready                         (response_ready),
        .response_id                            (response_id),
        .response_data                          (response_data),
        .response_error                         (response_error),
        .busy                                   (busy),
        .jobs_completed                         (jobs_completed)
    );

    always #5 clock_in = ~clock_in;

    int checks = 0;
    int errors = 0;

    resp_t resp_q[$];
    int    grant_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got event/timeout expected none", name);
    endtask

    function automatic mat_t diag(input logic [7:0] k);
        mat_t m = '0;
        for (int i = 0; i < 4; i++) m[i][i] = k;
        return m;
    endfunction

    function automatic mat_t fill(input logic [7:0] v);
        mat_t m;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) m[r][c] = v;
        return m;
    endfunction

    function automatic mat_t mat_mul(input mat_t a, input mat_t b);
        mat_t m;
        logic [7:0] acc;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                acc = '0;
                for (int k = 0; k < 4; k++) acc = acc + a[r][k] * b[k][c];
                m[r][c] = acc;
            end
        return m;
    endfunction

    // Requesters: valid while they still have jobs outstanding.
    int jobs_req[N];
    int jobs_done[N];

    always_comb begin
        for (int i = 0; i < N; i++) request_valid[i] = (jobs_req[i] != jobs_done[i]);
    end

    always @(posedge clock_in) begin
        for (int i = 0; i < N; i++)
            if (request_valid[i] && request_ready[i]) jobs_done[i] <= jobs_done[i] + 1;
    end

    // Tensor core model: done fires core_delay cycles into COMPUTE and then stays
    // high (sticky) until the next start; stale mode keeps it high into COMPUTE.
    int   core_delay = 1;
    bit   core_stuck = 1'b0;
    bit   core_stale = 1'b0;
    int   core_cnt;
    bit   core_active;
    logic done_r;
    mat_t core_out, core_prod;

    always @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            core_cnt    <= 0;
            core_active <= 1'b0;
            done_r      <= 1'b0;
            core_out    <= '0;
            core_prod   <= '0;
        end else if (tensor_core_register_file_write_enable) begin
            core_cnt    <= 0;
            core_active <= 1'b1;
            done_r      <= core_stale;
            core_out    <= core_stale ? fill(8'hEE) : '0;
            core_prod   <= mat_mul(tensor_core_input1, tensor_core_input2);
        end else if (core_active) begin
            core_cnt <= core_cnt + 1;
            if (!core_stuck && (core_cnt + 1 >= core_delay)) begin
                done_r      <= 1'b1;
                core_out    <= core_prod;
                core_active <= 1'b0;
            end else begin
                done_r <= 1'b0;
            end
        end
    end

    assign is_done_with_calculation = done_r;
    assign tensor_core_output       = core_out;

    // Monitor: samples on the falling edge, pops scoreboard entries.
    int   cycle = 0;
    int   load_cycle = 0;
    int   stall_n = 0;
    bit   prev_valid, prev_ready, prev_we, prev_err;
    logic [1:0] prev_id;
    mat_t prev_data;
    bit   jobs_pending = 1'b0;
    int   jobs_exp;

    always @(negedge clock_in) begin
        if (!reset_n_in) begin
            prev_valid   = 1'b0;
            prev_we      = 1'b0;
            jobs_pending = 1'b0;
        end else begin
            resp_t e;
            int    g;
            int    gi;
            cycle++;
            if (tensor_core_register_file_write_enable) begin
                chk("we_single_cycle", 128'(prev_we), 128'(0));
                load_cycle = cycle;
            end
            if (request_ready != '0) begin
                chk("ready_onehot", 128'($onehot(request_ready)), 128'(1));
                chk("ready_only_idle", 128'(busy), 128'(0));
            end
            if ((request_valid & request_ready) != '0) begin
                gi = 0;
                for (int i = 0; i < N; i++) if (request_ready[i]) gi = i;
                if (grant_q.size() == 0) fail("unexpected_grant");
                else begin
                    g = grant_q.pop_front();
                    chk("grant_id", 128'(gi), 128'(g));
                end
            end
            if (jobs_pending) begin
                chk("jobs_completed", 128'(jobs_completed), 128'(jobs_exp));
                jobs_pending = 1'b0;
            end
            if (response_valid) begin
                if (!prev_valid) begin
                    if (resp_q.size() == 0) fail("unexpected_response");
                    else chk("latency", 128'(cycle - load_cycle), 128'(resp_q[0].lat));
                end else if (!prev_ready) begin
                    stall_n++;
                    chk("stall_id", 128'(response_id), 128'(prev_id));
                    chk("stall_data", response_data, prev_data);
                    chk("stall_err", 128'(response_error), 128'(prev_err));
                end
                if (response_ready && resp_q.size() != 0) begin
                    e = resp_q.pop_front();
                    chk("resp_id", 128'(response_id), 128'(e.id));
                    chk("resp_data", response_data, e.data);
                    chk("resp_err", 128'(response_error), 128'(e.err));
                    jobs_pending = 1'b1;
                    jobs_exp     = e.jobs;
                end
            end
            prev_valid = response_valid;
            prev_ready = response_ready;
            prev_id    = response_id;
            prev_data  = response_data;
            prev_err   = response_error;
            prev_we    = tensor_core_register_file_write_enable;
        end
    end

    task automatic set_ops(input int i, input logic [7:0] k, input logic [7:0] v);
        request_input1[i] = diag(k);
        request_input2[i] = fill(v);
    endtask

    task automatic push_resp(input int id, input logic [7:0] v, input bit err, input int lat,
                             input int jobs);
        resp_t e;
        e.id   = id;
        e.data = err ? '0 : fill(v);
        e.err  = err;
        e.lat  = lat;
        e.jobs = jobs;
        resp_q.push_back(e);
    endtask

    task automatic wait_idle(input int max_cycles, input string name);
        int n = 0;
        while ((resp_q.size() != 0 || grant_q.size() != 0 || busy) && n < max_cycles) begin
            @(posedge clock_in);
            n++;
        end
        if (n >= max_cycles) begin
            fail(name);
            resp_q.delete();
            grant_q.delete();
        end
        repeat (2) @(posedge clock_in);
        #1;
    endtask

    initial begin
        int n;
        int stall_start;
        for (int i = 0; i < N; i++) begin
            jobs_req[i]  = 0;
            jobs_done[i] = 0;
        end

        // Reset values
        #1;
        chk("rst_ready", 128'(request_ready), 128'(0));
        chk("rst_we", 128'(tensor_core_register_file_write_enable), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_valid", 128'(response_valid), 128'(0));
        chk("rst_jobs", 128'(jobs_completed), 128'(0));
        chk("rst_data", response_data, 128'(0));
        chk("rst_in1", tensor_core_input1, 128'(0));
        chk("rst_id_err", {response_id, response_error}, 128'(0));
        repeat (3) @(posedge clock_in);
        @(negedge clock_in);
        reset_n_in = 1'b1;
        @(posedge clock_in);
        #1;

        // Single job: identity x all-3s, done 16 cycles into COMPUTE
        core_delay = 16;
        set_ops(0, 8'd1, 8'd3);
        grant_q.push_back(0);
        push_resp(0, 8'd3, 1'b0, 18, 1);
        jobs_req[0]++;
        wait_idle(200, "single_timeout");

        // Contention: pointer now 1, so order is 1,2,3,0,1
        core_delay = 1;
        set_ops(0, 8'd1, 8'd5);
        set_ops(1, 8'd2, 8'd6);
        set_ops(2, 8'd3, 8'd7);
        set_ops(3, 8'd4, 8'd8);
        grant_q.push_back(1); grant_q.push_back(2); grant_q.push_back(3);
        grant_q.push_back(0); grant_q.push_back(1);
        push_resp(1, 8'd12, 1'b0, 3, 2);
        push_resp(2, 8'd21, 1'b0, 3, 3);
        push_resp(3, 8'd32, 1'b0, 3, 4);
        push_resp(0, 8'd5,  1'b0, 3, 5);
        push_resp(1, 8'd12, 1'b0, 3, 6);
        jobs_req[0] += 1; jobs_req[1] += 2; jobs_req[2] += 1; jobs_req[3] += 1;
        wait_idle(300, "contention_timeout");

        // Back-pressure: req3 waits behind a 10-cycle stall on req2
        response_ready = 1'b0;
        grant_q.push_back(2); grant_q.push_back(3);
        push_resp(2, 8'd21, 1'b0, 3, 7);
        push_resp(3, 8'd32, 1'b0, 3, 8);
        jobs_req[2]++; jobs_req[3]++;
        stall_start = stall_n;
        n = 0;
        while (!response_valid && n < 100) begin
            @(posedge clock_in);
            #1;
            n++;
        end
        if (n >= 100) fail("stall_valid_timeout");
        repeat (10) @(posedge clock_in);
        #1;
        response_ready = 1'b1;
        wait_idle(200, "stall_timeout");
        chk("stall_cycles", 128'(stall_n - stall_start), 128'(10));

        // Timeout: done never rises
        core_stuck = 1'b1;
        grant_q.push_back(0);
        push_resp(0, 8'd0, 1'b1, T + 1, 8);
        jobs_req[0]++;
        wait_idle(300, "watchdog_timeout");
        core_stuck = 1'b0;

        // Stale done held into the first COMPUTE cycle
        core_stale = 1'b1;
        core_delay = 9;
        grant_q.push_back(1);
        push_resp(1, 8'd12, 1'b0, 11, 9);
        jobs_req[1]++;
        wait_idle(200, "stale_timeout");
        core_stale = 1'b0;

        // Reset mid-COMPUTE
        core_delay = 20;
        grant_q.push_back(1);
        jobs_req[1]++;
        n = 0;
        while (!tensor_core_register_file_write_enable && n < 50) begin
            @(posedge clock_in);
            #1;
            n++;
        end
        if (n >= 50) fail("reset_load_timeout");
        repeat (3) @(posedge clock_in);
        #2;
        chk("busy_before_reset", 128'(busy), 128'(1));
        #1;
        reset_n_in = 1'b0;
        #1;
        chk("arst_busy", 128'(busy), 128'(0));
        chk("arst_we", 128'(tensor_core_register_file_write_enable), 128'(0));
        chk("arst_valid", 128'(response_valid), 128'(0));
        chk("arst_jobs", 128'(jobs_completed), 128'(0));
        chk("arst_in1", tensor_core_input1, 128'(0));
        @(negedge clock_in);
        reset_n_in = 1'b1;
        @(posedge clock_in);
        #1;
        core_delay = 1;
        grant_q.push_back(0); grant_q.push_back(2);
        push_resp(0, 8'd5,  1'b0, 3, 1);
        push_resp(2, 8'd21, 1'b0, 3, 2);
        jobs_req[0]++; jobs_req[2]++;
        wait_idle(200, "post_reset_timeout");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tensor_core_job_scheduler.md
Name: tensor_core_job_scheduler

Overview:
Shares one small tensor core (4x4 matrix multiply, write-enable start, done flag) among NUM_REQUESTERS clients.
- Round-robin arbitration selects one request.
- The winner's operands are latched and the core is driven through load and compute.
- Result capture is guarded by a watchdog timeout.
- Each result returns with the requester ID over a valid/ready response channel.
- Sits between the requester register files and the tensor core instance.

Parameters:
NUM_REQUESTERS, 4, number of clients (2..8)
BUS_WIDTH, 8, element width in bits
TIMEOUT_CYCLES, 64, max COMPUTE cycles before error response
ID_WIDTH, $clog2(NUM_REQUESTERS), requester ID width

Ports:
clock_in  in  1  single clock, all state on posedge
reset_n_in  in  1  asynchronous, active-low reset
request_valid  in  [NUM_REQUESTERS]  client i has a job
request_ready  out  [NUM_REQUESTERS]  one-hot accept, combinational in IDLE
request_input1  in  [NUM_REQUESTERS][4][4]xBUS_WIDTH  A operands
request_input2  in  [NUM_REQUESTERS][4][4]xBUS_WIDTH  B operands
tensor_core_register_file_write_enable  out  1  core start/clear
tensor_core_input1  out  [4][4]xBUS_WIDTH  latched A
tensor_core_input2  out  [4][4]xBUS_WIDTH  latched B
tensor_core_output  in  [4][4]xBUS_WIDTH  core result
is_done_with_calculation  in  1  core done flag
response_valid  out  1  result available
response_ready  in  1  consumer accepts
response_id  out  ID_WIDTH  granted requester
response_data  out  [4][4]xBUS_WIDTH  captured result
response_error  out  1  watchdog expired
busy  out  1  state != IDLE
jobs_completed  out  16  saturating count of error-free responses

Behaviour:
Reset (async, reset_n_in=0) forces the following, independent of clock:
- state=IDLE; rr_pointer=0.
- Every output register to 0: write_enable, operand latches, response_*, busy, jobs_completed.
- request_ready=0.
- Reset mid-job abandons the job. No response is issued. The requester must re-request.

States:
IDLE
- Arbiter picks the first valid index at or after rr_pointer, modulo N.
- request_ready[winner]=1 only.
- On valid&ready: latch both operand arrays and the ID, go to LOAD.
- Requesters may drop valid before the handshake without effect.
LOAD (1 cycle)
- write_enable=1; latched operands are driven.
- Go to COMPUTE; watchdog=0.
COMPUTE
- write_enable=0.
- is_done_with_calculation is ignored on the first COMPUTE cycle (stale flag mask). It is sampled from the second cycle on.
- On done: response_data<=tensor_core_output, response_error<=0, go to RESPOND.
- Watchdog increments each cycle. If watchdog==TIMEOUT_CYCLES-1 with no done: response_data<=0, response_error<=1, go to RESPOND.
- If done and timeout occur in the same cycle, done wins.
RESPOND
- response_valid=1; data, ID and error are held stable until response_ready.
- On valid&ready: rr_pointer<=response_id+1 (wrap at N-1 to 0), jobs_completed++ if !error (saturate at 16'hFFFF), go to IDLE.
- No new grant occurs in the same cycle as the response handshake.

General rules:
- tensor_core_input1/2 stay stable from LOAD through RESPOND exit.
- Best-case latency: grant cycle G, LOAD at G+1, first done sample at G+3, response_valid at D+1, where D is the cycle done is seen.
- Throughput: one job per (3 + compute + response-stall) cycles.
- No arithmetic on data; widths pass through unchanged.

Decomposition:
Package tensor_core_pkg holds:
- BUS_WIDTH
- element_t
- matrix_t ([4][4] element_t)
- scheduler_state_t enum {IDLE, LOAD, COMPUTE, RESPOND}
- MATRIX_DIM=4

One natural sub-module: round_robin_arbiter.
- Combinational, parameterised N.
- Inputs: request vector, rr_pointer.
- Outputs: one-hot grant, grant index, any_grant.

Test Plan:
- Single job: req0 valid, A=identity, B=all 3s, core model done 16 cycles after start, response_ready=1 -> ready[0] pulses once; write_enable high exactly 1 cycle; response_id=0, data all 3s, error=0, jobs_completed=1.
- Contention: req0..3 all valid continuously, responses accepted immediately -> grant order 0,1,2,3,0; each ID appears once per 4 jobs.
- Back-pressure: response_ready low 10 cycles after response_valid -> valid, ID and data stable 10 cycles; no new request_ready during stall; exits on first ready.
- Timeout: core done stuck 0 -> response_valid after exactly TIMEOUT_CYCLES COMPUTE cycles; error=1, data=0, jobs_completed unchanged.
- Stale done: done held 1 entering COMPUTE then dropped, real done 8 cycles later -> first-cycle done ignored; response carries result from real done.
- Reset mid-COMPUTE: reset_n_in low asynchronously -> busy and write_enable go 0 immediately. After release: IDLE, rr_pointer=0, no response for the aborted job, req0 granted first.
